// File: rtl/fp_add_pkg.sv
// Shared definitions for the fp adder mantissa datapath.
//   MANT_W     : mantissa word width used by the adder
//   TAG_W_DFLT : default sideband tag width
//   clog2_cnt  : width needed to hold a count in the range 0..width
package fp_add_pkg;

  localparam int MANT_W     = 27;
  localparam int TAG_W_DFLT = 4;

  function automatic int clog2_cnt(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzc_comb.sv
// Combinational leading-zero counter, MSB counts as position 0.
//   data_i : word to scan
//   zero_o : data_i is all zeros
//   lzc_o  : number of leading zeros (WIDTH when data_i is zero)
// The word is padded at the LSB end to a power of two and reduced by a
// heap-indexed binary tree: node i has children 2i (more significant half)
// and 2i+1, and the leaves are nodes P/2 .. P-1.
module lzc_comb
  import fp_add_pkg::*;
#(
  parameter int  WIDTH = MANT_W,
  localparam int CNT_W = clog2_cnt(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             zero_o,
  output logic [CNT_W-1:0] lzc_o
);

  localparam int LOGP = $clog2(WIDTH);
  localparam int P    = 1 << LOGP;

  logic [P-1:0]    pw;
  logic            z_n   [1:P-1];
  logic [LOGP-1:0] cnt_n [1:P-1];

  // Zero padding below the LSB never changes the count of a non-zero word.
  always_comb begin
    pw = '0;
    pw[P-1 -: WIDTH] = data_i;
  end

  for (genvar m = 0; m < P / 2; m++) begin : g_leaf
    localparam int HB = P - 1 - 2 * m;
    assign z_n[P/2+m]   = ~(pw[HB] | pw[HB-1]);
    assign cnt_n[P/2+m] = pw[HB] ? '0 : LOGP'(1);
  end

  // When the upper half is empty the count is the upper half's size plus
  // the lower half's count; otherwise the upper half decides alone.
  for (genvar i = 1; i < P / 2; i++) begin : g_node
    localparam int D  = $clog2(i + 1) - 1;
    localparam int CH = P >> (D + 1);
    assign z_n[i]   = z_n[2*i] & z_n[2*i+1];
    assign cnt_n[i] = z_n[2*i] ? (LOGP'(CH) + cnt_n[2*i+1]) : cnt_n[2*i];
  end

  assign zero_o = z_n[1];
  assign lzc_o  = z_n[1] ? CNT_W'(WIDTH) : CNT_W'(cnt_n[1]);

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero count and normalise pipeline for the post-add
// mantissa. Stage 1 counts leading zeros and clamps the shift to in_lim,
// stage 2 applies the left shift. Valid/ready on both sides, no skid buffer.
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid/in_ready               : input handshake
//   in_data, in_lim, in_tag         : mantissa, max shift, sideband tag
//   out_valid/out_ready             : output handshake
//   out_data                        : normalised mantissa
//   out_lzc, out_shift              : leading-zero count, shift applied
//   out_zero, out_lim_hit, out_tag  : zero flag, clamp flag, tag
module lzc_norm_pipe
  import fp_add_pkg::*;
#(
  parameter int  WIDTH = MANT_W,
  parameter int  TAG_W = TAG_W_DFLT,
  localparam int CNT_W = clog2_cnt(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_lim,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_lzc,
  output logic [CNT_W-1:0] out_shift,
  output logic             out_zero,
  output logic             out_lim_hit,
  output logic [TAG_W-1:0] out_tag
);

  function automatic logic [CNT_W-1:0] clamp_shift(input logic [CNT_W-1:0] lzc,
                                                   input logic [CNT_W-1:0] lim,
                                                   input logic             zero);
    if (zero)       return '0;
    else if (lzc > lim) return lim;
    else            return lzc;
  endfunction

  logic             lzc_zero;
  logic [CNT_W-1:0] lzc_cnt;

  logic             vld_p1_q, vld_p2_q;
  logic             adv_p1, adv_p2, accept;

  logic [WIDTH-1:0] data_p1_q;
  logic [TAG_W-1:0] tag_p1_q;
  logic [CNT_W-1:0] lzc_p1_q, shift_p1_q, shift_p1_d;
  logic             zero_p1_q, hit_p1_q, hit_p1_d;
  logic [WIDTH-1:0] data_p2_d;

  lzc_comb #(.WIDTH(WIDTH)) u_lzc (
    .data_i (in_data),
    .zero_o (lzc_zero),
    .lzc_o  (lzc_cnt)
  );

  assign adv_p2   = !vld_p2_q || out_ready;
  assign adv_p1   = !vld_p1_q || adv_p2;
  assign in_ready = rst_n && adv_p1;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (adv_p1) vld_p1_q <= accept;
      if (adv_p2) vld_p2_q <= vld_p1_q;
    end
  end

  // ---- stage 1: count and clamp ----
  assign shift_p1_d = clamp_shift(lzc_cnt, in_lim, lzc_zero);
  assign hit_p1_d   = !lzc_zero && (lzc_cnt > in_lim);

  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1_q  <= in_data;
      tag_p1_q   <= in_tag;
      lzc_p1_q   <= lzc_cnt;
      shift_p1_q <= shift_p1_d;
      zero_p1_q  <= lzc_zero;
      hit_p1_q   <= hit_p1_d;
    end
  end

  // ---- stage 2: normalising shift ----
  assign data_p2_d = data_p1_q << shift_p1_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_lzc     <= '0;
      out_shift   <= '0;
      out_zero    <= 1'b0;
      out_lim_hit <= 1'b0;
      out_tag     <= '0;
    end else if (adv_p2 && vld_p1_q) begin
      out_data    <= data_p2_d;
      out_lzc     <= lzc_p1_q;
      out_shift   <= shift_p1_q;
      out_zero    <= zero_p1_q;
      out_lim_hit <= hit_p1_q;
      out_tag     <= tag_p1_q;
    end
  end

  assign out_valid = vld_p2_q;

endmodule

// File: doc/lzc_norm_pipe.md
Name: lzc_norm_pipe

Overview:
- Parametrised, pipelined leading-zero counter and normaliser for the fp adder's post-add mantissa path.
- Finds the leading one of a WIDTH-bit word (MSB = position 0), reports the count and an all-zero flag, and left-shifts the word to normalise it.
- Shift is clamped by a per-beat limit, so the exponent never drops below the minimum (denormal results).
- Valid/ready handshake in, valid/ready handshake out, with full backpressure.

Parameters:
- WIDTH, 27, mantissa word width (>= 2)
- TAG_W, 4, sideband tag width passed through unchanged (>= 1)
- CNT_W, derived localparam = $clog2(WIDTH+1), count width (5 for WIDTH=27)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- in_data  in  WIDTH  unnormalised mantissa
- in_lim  in  CNT_W  maximum allowed left shift
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  normalised mantissa
- out_lzc  out  CNT_W  leading-zero count of in_data (WIDTH if zero)
- out_shift  out  CNT_W  shift actually applied
- out_zero  out  1  in_data was all zeros
- out_lim_hit  out  1  lzc exceeded in_lim, so the shift was clamped
- out_tag  out  TAG_W  tag of this beat

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, s1_valid=0 and s2_valid=0. All registered outputs are cleared to 0, including out_valid, out_data, out_lzc, out_shift, out_zero, out_lim_hit and out_tag.
- in_ready is 0 while rst_n=0. In-flight beats are discarded on reset, with no partial output.
- Stage 1 (registered):
  - lzc = number of leading zeros counted from bit WIDTH-1.
  - zero = (in_data == 0).
  - shift = zero ? 0 : min(lzc, in_lim).
  - lim_hit = !zero && (lzc > in_lim).
  - in_data and in_tag are captured alongside.
- Stage 2 (registered):
  - out_data = stage-1 data << shift, with zeros shifted in; width stays WIDTH and MSB bits shifted out are discarded (they are zero by construction).
- Zero input: lzc = WIDTH, shift = 0, out_data = 0, lim_hit = 0, zero = 1. No output is left undefined.
- in_lim >= WIDTH is legal; it behaves as an unlimited shift.
- Latency: exactly 2 cycles from acceptance (in_valid && in_ready) to out_valid when out_ready stays 1. Throughput is 1 beat/cycle.
- Handshake:
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = rst_n && (!s1_valid || s2 advances). This is combinational from out_ready, and there is no skid buffer.
- Valid/ready rules:
  - A beat transfers only when valid and ready are both 1 on the same edge.
  - out_* must hold stable while out_valid && !out_ready.
  - Once out_valid is raised, it does not drop until the beat is consumed.
- Simultaneous events: an accept and an emit on the same edge with both stages full keeps both full. There is no bubble, no duplication and no reordering.
- Arithmetic: all comparisons are unsigned at CNT_W width.

Decomposition:
- Shared package fp_add_pkg:
  - MANT_W = 27
  - TAG_W default
  - function clog2_cnt(width) giving CNT_W
- Sub-module lzc_comb (parametrised WIDTH, combinational):
  - Built as a log-depth tree of 2-bit leaf encoders merged pairwise.
  - Returns {zero, lzc}.
  - Instantiated once in stage 1.
- Stage registers and handshake logic live in lzc_norm_pipe.

Test Plan:
- Leading-one at MSB: in_data=27'h4000000, in_lim=26, out_ready=1 -> 2 cycles later out_lzc=0, out_shift=0, out_data=27'h4000000, out_zero=0, out_lim_hit=0.
- Leading-one at LSB: in_data=27'h0000001, in_lim=26 -> out_lzc=26, out_shift=26, out_data=27'h4000000, out_lim_hit=0.
- Zero input: in_data=0, in_lim=3 -> out_zero=1, out_lzc=27, out_shift=0, out_data=0, out_lim_hit=0.
- Clamp: in_data=27'h0000100 (lzc=18), in_lim=5 -> out_shift=5, out_data=27'h0002000, out_lim_hit=1, out_lzc=18.
- Backpressure: 4 back-to-back beats with tags 1..4, out_ready=0 for 3 cycles, then 1 -> in_ready drops after 2 accepts. out_* stay stable while stalled. Outputs arrive in tag order 1,2,3,4 with none lost or duplicated.
- Reset mid-flight: 2 beats in flight, rst_n=0 for one edge -> on that edge out_valid=0 and all outputs=0. in_ready=0 during reset. No in-flight beat appears after release. A fresh beat then completes in 2 cycles.
